// File: rtl/rr_arb_2_1_if.sv
// Handshake bundle between the two request sources, the arbiter and the
// downstream consumer of the 2:1 mux output.
interface rr_arb_2_1_if #(
    parameter int CNT_W = 4
) ();
    logic [1:0]       req;
    logic [1:0]       last;
    logic             out_ready;
    logic [1:0]       gnt;
    logic             sel;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;

    // Sources and consumer side.
    modport master (
        output req, last, out_ready,
        input  gnt, sel, out_valid, beat_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, last, out_ready,
        output gnt, sel, out_valid, beat_cnt
    );
endinterface

// File: rtl/rr_arb_2_1.sv
// Two-source round-robin arbiter driving the select of the downstream 2:1 mux.
// Grants are locked per burst, bounded by HOLD_MAX beats when the other side waits.
module rr_arb_2_1 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb_2_1_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    state_t           r_state;
    logic             r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;

    state_t           w_state_nxt;
    logic             w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sel_nxt;

    logic             w_busy;
    logic             w_own;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_beat;
    logic             w_release;
    logic             w_pick;

    assign w_busy    = (r_state != S_IDLE);
    assign w_own     = (r_state == S_GRANT1);
    assign w_own_req = bus.req[w_own];
    assign w_oth_req = bus.req[~w_own];
    assign w_beat    = w_busy && w_own_req && bus.out_ready;
    // An abort needs no beat; last or the fairness limit only act on a beat.
    assign w_release = w_busy && (!w_own_req ||
                       (w_beat && (bus.last[w_own] || ((r_cnt == CNT_MAX) && w_oth_req))));
    // On abort req[own] is already low, so the pointer choice falls to the other source.
    assign w_pick    = bus.req[r_ptr] ? r_ptr : ~r_ptr;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        if (!w_busy || w_release) begin
            w_cnt_nxt = '0;
            if (bus.req == 2'b00) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = w_pick ? S_GRANT1 : S_GRANT0;
                w_ptr_nxt   = ~w_pick;
                w_sel_nxt   = w_pick;
            end
        end else if (w_beat && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bus.gnt       = {r_state == S_GRANT1, r_state == S_GRANT0};
        bus.sel       = r_sel;
        bus.out_valid = w_busy && w_own_req;
        bus.beat_cnt  = r_cnt;
    end
endmodule

// File: tb/tb_rr_arb_2_1.sv
// Directed bench for rr_arb_2_1 with a per-cycle reference model of grant ownership.
module tb_rr_arb_2_1;
    localparam int HOLD  = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en   = 1'b0;

    rr_arb_2_1_if #(.CNT_W(CNT_W)) bus ();

    rr_arb_2_1 #(.HOLD_MAX(HOLD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: who owns the output (-1 nobody), who is preferred next, beats so far.
    typedef struct {
        int owner;
        bit ptr;
        int cnt;
        bit sel;
    } mstate_t;

    mstate_t m = '{owner: -1, ptr: 1'b0, cnt: 0, sel: 1'b0};

    function automatic mstate_t mnext(mstate_t s, bit r, bit [1:0] q, bit [1:0] l, bit rdy);
        mstate_t n;
        bit      rearb;
        int      k;
        n     = s;
        rearb = 1'b0;
        k     = s.owner;
        if (r) begin
            n = '{owner: -1, ptr: 1'b0, cnt: 0, sel: 1'b0};
            return n;
        end
        if (k < 0) rearb = 1'b1;
        else if (!q[k]) rearb = 1'b1;
        else if (rdy) begin
            if (l[k] || (s.cnt == HOLD - 1 && q[1-k])) rearb = 1'b1;
            else if (s.cnt < HOLD - 1) n.cnt = s.cnt + 1;
        end
        if (rearb) begin
            n.cnt = 0;
            if (q == 2'b00) n.owner = -1;
            else begin
                n.owner = q[s.ptr] ? int'(s.ptr) : 1 - int'(s.ptr);
                n.ptr   = (n.owner == 0);
                n.sel   = (n.owner == 1);
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= mnext(m, rst, bus.req, bus.last, bus.out_ready);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_gnt", 32'(bus.gnt),
                  (m.owner == 0) ? 32'h1 : (m.owner == 1) ? 32'h2 : 32'h0);
            check("cmp_sel", 32'(bus.sel), 32'(m.sel));
            check("cmp_cnt", 32'(bus.beat_cnt), 32'(m.cnt));
            check("cmp_valid", 32'(bus.out_valid),
                  32'((m.owner >= 0) && bus.req[m.owner[0]]));
        end
    end

    // Apply inputs, cross one rising edge, return a little after it.
    task automatic cyc(input bit r, input logic [1:0] q, input logic [1:0] l, input bit rdy);
        rst           = r;
        bus.req       = q;
        bus.last      = l;
        bus.out_ready = rdy;
        @(posedge clk);
        #3;
    endtask

    task automatic expect_out(input string name, input logic [1:0] g, input logic s,
                              input logic [CNT_W-1:0] c);
        check({name, "_gnt"}, 32'(bus.gnt), 32'(g));
        check({name, "_sel"}, 32'(bus.sel), 32'(s));
        check({name, "_cnt"}, 32'(bus.beat_cnt), 32'(c));
    endtask

    logic [1:0] alt_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        // Reset priority with both sources requesting.
        cyc(1, 2'b11, 2'b00, 1);
        cmp_en = 1'b1;
        expect_out("rst0", 2'b00, 1'b0, 0);
        check("rst0_valid", 32'(bus.out_valid), 0);
        cyc(1, 2'b11, 2'b00, 1);
        expect_out("rst1", 2'b00, 1'b0, 0);
        cyc(0, 2'b11, 2'b00, 1);
        expect_out("rst_rel", 2'b01, 1'b0, 0);
        cyc(0, 2'b00, 2'b00, 1);
        expect_out("to_idle", 2'b00, 1'b0, 0);

        // Single-source burst on source 1, last on third beat.
        cyc(0, 2'b10, 2'b00, 1);
        expect_out("b1_grant", 2'b10, 1'b1, 0);
        cyc(0, 2'b10, 2'b00, 1);
        check("b1_cnt1", 32'(bus.beat_cnt), 1);
        cyc(0, 2'b10, 2'b00, 1);
        check("b1_cnt2", 32'(bus.beat_cnt), 2);
        cyc(0, 2'b10, 2'b10, 1);
        expect_out("b1_regrant", 2'b10, 1'b1, 0);
        cyc(0, 2'b00, 2'b00, 1);
        expect_out("b1_idle", 2'b00, 1'b1, 0);

        // Fair alternation with last every beat.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b11, 2'b11, 1);
            check("alt_gnt", 32'(bus.gnt), 32'(alt_seq[i]));
            check("alt_valid", 32'(bus.out_valid), 1);
        end
        cyc(0, 2'b00, 2'b00, 1);
        check("alt_idle", 32'(bus.gnt), 0);

        // Forced switch after HOLD beats.
        cyc(0, 2'b11, 2'b00, 1);
        expect_out("fs_grant", 2'b01, 1'b0, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 2'b11, 2'b00, 1);
            check("fs_cnt", 32'(bus.beat_cnt), i);
        end
        cyc(0, 2'b11, 2'b00, 1);
        expect_out("fs_switch", 2'b10, 1'b1, 0);

        // Lone requester keeps the grant and saturates.
        cyc(0, 2'b01, 2'b00, 1);
        expect_out("sat_grant", 2'b01, 1'b0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 2'b01, 2'b00, 1);
        expect_out("sat_hold", 2'b01, 1'b0, 3);

        // Backpressure freezes everything despite last.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b11, 2'b01, 0);
            expect_out("bp_frz", 2'b01, 1'b0, 3);
        end
        cyc(0, 2'b11, 2'b01, 1);
        expect_out("bp_rel", 2'b10, 1'b1, 0);

        // Abort of source 0 mid-burst hands over at once.
        cyc(0, 2'b11, 2'b10, 1);
        expect_out("ab_g0", 2'b01, 1'b0, 0);
        cyc(0, 2'b11, 2'b00, 1);
        check("ab_cnt", 32'(bus.beat_cnt), 1);
        cyc(0, 2'b10, 2'b00, 1);
        expect_out("ab_sw", 2'b10, 1'b1, 0);

        // Reset in the middle of a source 1 burst.
        cyc(0, 2'b10, 2'b00, 1);
        cyc(0, 2'b10, 2'b00, 1);
        expect_out("mr_pre", 2'b10, 1'b1, 2);
        cyc(1, 2'b11, 2'b00, 1);
        expect_out("mr_rst", 2'b00, 1'b0, 0);
        check("mr_valid", 32'(bus.out_valid), 0);
        cyc(0, 2'b11, 2'b00, 1);
        expect_out("mr_rel", 2'b01, 1'b0, 0);

        cyc(0, 2'b00, 2'b00, 1);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_arb_2_1.md
# rr_arb_2_1

Two-source round-robin arbiter that generates the select for the 2:1 mux stage (`mux_2_1`) directly downstream. It accepts per-source request and end-of-burst indications, issues a registered one-hot grant, and drives `sel` so the mux forwards the granted source. The arbiter locks the grant for a burst, enforces a beat-count fairness limit, and handshakes with a downstream consumer through `out_valid`/`out_ready`.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum beats per grant before a forced switch, applied only when the other source is requesting. Legal range is 1..2^CNT_W.
- `CNT_W`, default 4: width of the beat counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-source request; `req[k]` high means source k has a beat available.
- `last`  in  2  `last[k]` marks the current beat of source k as the final beat of its burst.
- `out_ready`  in  1  downstream accepts a beat this cycle.
- `gnt`  out  2  one-hot grant (registered); `00` means idle.
- `sel`  out  1  mux select (registered): 0 selects `i[0]`, 1 selects `i[1]`.
- `out_valid`  out  1  granted source has a beat on the mux output.
- `beat_cnt`  out  CNT_W  beats transferred in the current grant.

## Operation
- **Beat definition:** a beat is a cycle with `out_valid && out_ready`.
- **States:**
  - IDLE: `gnt=00`.
  - GRANT0: `gnt=01`, `sel=0`.
  - GRANT1: `gnt=10`, `sel=1`.
- **Priority pointer:**
  - Points to the source preferred on the next arbitration.
  - Reset value is 0.
  - On every grant issue, set to the opposite of the source just granted.
- **IDLE:**
  - If `req` is non-zero, grant `req[ptr]` if it is set, otherwise the other requesting source.
  - Otherwise stay in IDLE.
- **GRANTk, `out_valid` and hold:**
  - `out_valid = req[k]` (combinational from the registered state).
  - `out_ready=0` holds everything: state, `beat_cnt` and grant are unchanged.
- **GRANTk, release conditions (evaluated at the clock edge):**
  - (a) a beat with `last[k]=1`;
  - (b) a beat with `beat_cnt==HOLD_MAX-1` and `req[1-k]=1`;
  - (c) `req[k]=0` (abort, no beat).
- **On release:** re-arbitrate in the same edge using the pointer and current `req`, masking `req[k]` on abort.
  - If the result is a source, go directly to its GRANT state with no idle bubble. This may re-grant k if k is the only requester.
  - If nothing is requesting, go to IDLE.
- **`beat_cnt`:**
  - Clears to 0 on every grant issue and in IDLE.
  - Increments on each beat.
  - Saturates at HOLD_MAX-1 when the other source is not requesting; the grant then continues until `last` or abort.
- **`sel`:**
  - Updates only on grant issue.
  - Holds its last value in IDLE.
- **Invariant:** `gnt` is never `11`.

## Timing
- **Reset values:** `gnt=00`, `sel=0`, `out_valid=0`, `beat_cnt=0`, state IDLE, pointer 0.
- **Reset priority:** reset overrides every other event, including a mid-burst grant, on the next edge.
- **Arbitration latency:** `req` sampled high in IDLE at edge N gives `gnt`/`sel` valid after edge N, so `out_valid` can assert in the cycle following that edge.
- **Back-to-back handover:**
  - The beat with `last` at edge N gives the new `gnt` after edge N.
  - The next beat is possible in cycle N+1.
  - Throughput is one beat per cycle across grant switches.
- **Simultaneous `last` and forced switch:** both mean release; the behaviour is identical.
- **Requests arriving in the same cycle:** the pointer decides.
- **HOLD_MAX=1:** forces alternation on every beat while both sources request.

## Test plan
1. **Reset priority:** hold `rst=1` for 2 cycles with `req=11`, `out_ready=1`.
   - During reset: `gnt=00`, `sel=0`, `out_valid=0`, `beat_cnt=0`.
   - First edge after reset release: `gnt=01`, `sel=0`.
2. **Single-source burst:** `req=10`, `out_ready=1`, `last[1]` on the 3rd beat, then `req=00`.
   - `gnt=10` and `sel=1` one cycle after the request.
   - `beat_cnt` goes 0,1,2.
   - Then `gnt=00` with `sel` held at 1.
3. **Fair alternation:** `req=11`, `last=11` every cycle, `out_ready=1`.
   - `gnt` sequence is 01,10,01,10.
   - `out_valid` stays continuously high, with no bubble.
4. **Forced switch:** `HOLD_MAX=4`; source 0 never asserts `last`; `req=11`.
   - After 4 beats (`beat_cnt` 0..3), `gnt` switches to `10`.
   - With `req[1]` dropped instead, source 0 keeps the grant and `beat_cnt` stays saturated at 3.
5. **Backpressure and abort:**
   - Mid-grant `out_ready=0` for 3 cycles while `last[0]=1`: `gnt`, `beat_cnt` and `sel` are frozen and no release occurs; release happens on the beat after `out_ready` returns to 1.
   - Dropping `req[0]` mid-burst while `req[1]=1`: `gnt=10` at the next edge.
6. **Reset mid-burst:** assert `rst` during GRANT1 with `beat_cnt=2`.
   - Next edge: all outputs at reset values.
   - After release with `req=11`, source 0 is granted first.
